// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// The op encodings are also used by the Execute stage's funct-to-op mapping,
// so they must stay in step with the core.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MDU_IDLE     = 2'd0,
        MDU_MUL_ITER = 2'd1,
        MDU_DIV_ITER = 2'd2,
        MDU_FIX      = 2'd3
    } mdu_state_t;

endpackage

// File: rtl/mdu_cond_negate.sv
// Conditional two's-complement negation: result = neg ? -value : value.
// Ports:
//   value  - WIDTH-bit input
//   neg    - negate when high
//   result - WIDTH-bit output
module mdu_cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic [WIDTH-1:0] result
);

    assign result = neg ? (WIDTH'(0) - value) : value;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// Shift-add multiplier (LSB-first) and restoring divider operate on operand
// magnitudes; signs are applied on the final (FIX) edge.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, op           - request and operation (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   operand_a/operand_b - rS / rT values
//   busy                - iterative op in flight
//   done                - one-cycle pulse when hi/lo hold a new result
//   div_by_zero         - sticky flag from the last divide
//   hi, lo              - HI and LO registers
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    mdu_state_t       state, next_state;
    logic [CNT_W-1:0] counter;

    // operation context latched on the accept edge
    logic             is_div, neg_q, neg_r, dz;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd, raw_a;

    logic             signed_op, div_op, iter_op, accept;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign signed_op = (op == MDU_MULT) || (op == MDU_DIV);
    assign div_op    = (op == MDU_DIV)  || (op == MDU_DIVU);
    assign iter_op   = (op == MDU_MULT) || (op == MDU_MULTU) || div_op;
    assign accept    = (state == MDU_IDLE) && start && iter_op;
    assign busy      = (state != MDU_IDLE);

    mdu_cond_negate #(.WIDTH(WIDTH)) u_abs_a (
        .value(operand_a), .neg(signed_op & operand_a[WIDTH-1]), .result(mag_a));
    mdu_cond_negate #(.WIDTH(WIDTH)) u_abs_b (
        .value(operand_b), .neg(signed_op & operand_b[WIDTH-1]), .result(mag_b));

    // Multiply step: acc_hi accumulates, acc_lo holds the unconsumed multiplier
    // bits and receives product bits from the top as it shifts right.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign mul_hi_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // Divide step: acc_hi is the partial remainder, acc_lo shifts dividend
    // bits out of the top and quotient bits in at the bottom.
    logic [WIDTH:0]   div_shift, div_diff;
    logic             q_bit;
    logic [WIDTH-1:0] div_hi_nx, div_lo_nx;

    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign q_bit     = div_shift[WIDTH] | ~div_diff[WIDTH];
    assign div_hi_nx = q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo_nx = {acc_lo[WIDTH-2:0], q_bit};

    logic [WIDTH-1:0] step_hi, step_lo;

    assign step_hi = is_div ? div_hi_nx : mul_hi_nx;
    assign step_lo = is_div ? div_lo_nx : mul_lo_nx;

    // The FIX edge performs the final (WIDTH-th) step and applies the signs.
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient, remainder;

    mdu_cond_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
        .value({step_hi, step_lo}), .neg(neg_q), .result(product));
    mdu_cond_negate #(.WIDTH(WIDTH)) u_fix_quot (
        .value(step_lo), .neg(neg_q), .result(quotient));
    mdu_cond_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .value(step_hi), .neg(neg_r), .result(remainder));

    always_comb begin
        next_state = state;
        case (state)
            MDU_IDLE: begin
                if (accept) next_state = div_op ? MDU_DIV_ITER : MDU_MUL_ITER;
            end
            MDU_MUL_ITER, MDU_DIV_ITER: begin
                // counter reaches 1 on this edge: the remaining step runs in FIX
                if (counter == CNT_W'(2)) next_state = MDU_FIX;
            end
            MDU_FIX: next_state = MDU_IDLE;
            default: next_state = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MDU_IDLE;
            counter     <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            state <= next_state;
            done  <= 1'b0;
            case (state)
                MDU_IDLE: begin
                    if (start && op == MDU_MTHI) hi <= operand_a;
                    if (start && op == MDU_MTLO) lo <= operand_a;
                    if (accept) begin
                        counter     <= CNT_W'(WIDTH);
                        div_by_zero <= 1'b0;
                    end
                end
                MDU_MUL_ITER, MDU_DIV_ITER: counter <= counter - 1'b1;
                MDU_FIX: begin
                    counter <= counter - 1'b1;
                    done    <= 1'b1;
                    if (!is_div) begin
                        {hi, lo} <= product;
                    end else if (dz) begin
                        hi          <= raw_a;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                    end else begin
                        hi <= remainder;
                        lo <= quotient;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers carry no reset; they are only consumed under busy.
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div <= div_op;
            neg_q  <= signed_op & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            neg_r  <= signed_op & operand_a[WIDTH-1];
            dz     <= (operand_b == '0);
            raw_a  <= operand_a;
            acc_hi <= '0;
            acc_lo <= div_op ? mag_a : mag_b;
            opnd   <= div_op ? mag_b : mag_a;
        end else if (state == MDU_MUL_ITER || state == MDU_DIV_ITER) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: a 32-bit instance checked every cycle against an
// arithmetic reference model, plus an 8-bit instance with directed checks.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, dbz;
    logic [31:0] hi, lo;

    logic        rst_n8 = 1'b0;
    logic        start8 = 1'b0;
    logic [2:0]  op8 = 3'd0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, dbz8;
    logic [7:0]  hi8, lo8;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .operand_a(a), .operand_b(b), .busy(busy), .done(done),
        .div_by_zero(dbz), .hi(hi), .lo(lo));

    mul_div_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n8), .start(start8), .op(op8),
        .operand_a(a8), .operand_b(b8), .busy(busy8), .done(done8),
        .div_by_zero(dbz8), .hi(hi8), .lo(lo8));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Reference result of one 32-bit operation, from plain arithmetic.
    function automatic void model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] h, output logic [31:0] l, output logic z);
        longint      sp;
        logic [63:0] up;
        z = 1'b0;
        h = '0;
        l = '0;
        case (o)
            MDU_MULT: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                {h, l} = sp;
            end
            MDU_MULTU: begin
                up = {32'b0, x} * {32'b0, y};
                {h, l} = up;
            end
            MDU_DIV, MDU_DIVU: begin
                if (y == 0) begin
                    h = x; l = '1; z = 1'b1;
                end else if (o == MDU_DIVU) begin
                    l = x / y; h = x % y;
                end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    l = x; h = '0;
                end else begin
                    l = $signed(x) / $signed(y);
                    h = $signed(x) % $signed(y);
                end
            end
            default: ;
        endcase
    endfunction

    // Expected architectural state: a countdown of cycles until the pending
    // result lands in hi/lo.
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_dbz = 1'b0, m_done = 1'b0, p_dbz = 1'b0;
    int          m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; m_dbz = 1'b0; m_done = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz; m_done = 1'b1;
                end
            end else if (start) begin
                if (op == MDU_MTHI) m_hi = a;
                else if (op == MDU_MTLO) m_lo = a;
                else if (op <= MDU_DIVU) begin
                    model_op(op, a, b, p_hi, p_lo, p_dbz);
                    m_dbz  = 1'b0;
                    m_left = 32;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("m_busy", busy, m_left != 0);
        chk("m_done", done, m_done);
        chk("m_dbz", dbz, m_dbz);
        chk("m_hi", hi, m_hi);
        chk("m_lo", lo, m_lo);
    end

    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input int inject, input logic [31:0] eh, input logic [31:0] el,
                          input logic ez, input string nm);
        int n, nb;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(negedge clk);
        start = 1'b0;
        n = 0; nb = 0;
        while (!done && n < 200) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
            start = (inject > 0 && n == inject);
            if (start) begin op = MDU_DIVU; a = 32'd5; b = '0; end
        end
        start = 1'b0;
        chk({nm, "_lat"}, n, 32);
        chk({nm, "_busy"}, nb, 32);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
        chk({nm, "_dbz"}, dbz, ez);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;

        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
        run_op(MDU_MULT,  32'hFFFF_FFF9, 32'd6,         0, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, "mult_neg");
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2,         0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg");
        run_op(MDU_DIVU,  32'd100,       32'd0,         0, 32'd100,       32'hFFFF_FFFF, 1'b1, "divu_zero");
        run_op(MDU_MULTU, 32'd3,         32'd4,         0, 32'd0,         32'd12,        1'b0, "multu_small");
        run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0,         32'h8000_0000, 1'b0, "div_ovf");
        run_op(MDU_MULT,  32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000, 32'd0,         1'b0, "mult_min");
        run_op(MDU_DIVU,  32'd1000,      32'd7,         0, 32'd6,         32'd142,       1'b0, "divu_1000");
        run_op(MDU_MULTU, 32'h0001_0000, 32'h0003_0000, 5, 32'd3,         32'd0,         1'b0, "multu_inj");

        @(negedge clk);
        start = 1'b1; op = MDU_MTHI; a = 32'h1234;
        @(negedge clk);
        op = MDU_MTLO; a = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        chk("mt_busy", busy, 0);
        chk("mt_done", done, 0);
        chk("mt_hi", hi, 32'h1234);
        chk("mt_lo", lo, 32'h5678);

        start = 1'b1; op = 3'd6; a = 32'hDEAD; b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rsv_busy", busy, 0);
        chk("rsv_hi", hi, 32'h1234);

        // 8-bit instance
        rst_n8 = 1'b1;
        @(negedge clk);
        start8 = 1'b1; op8 = MDU_DIVU; a8 = 8'd200; b8 = 8'd7;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("w8_lat", n, 8);
        chk("w8_lo", lo8, 8'd28);
        chk("w8_hi", hi8, 8'd4);

        @(negedge clk);
        start8 = 1'b1; a8 = 8'd250; b8 = 8'd3;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("w8_busy_mid", busy8, 1);
        #1 rst_n8 = 1'b0;
        #1;
        chk("w8_rst_busy", busy8, 0);
        chk("w8_rst_hi", hi8, 0);
        chk("w8_rst_lo", lo8, 0);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (done8) n++;
        end
        rst_n8 = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) n++;
        end
        chk("w8_no_done", n, 0);
        chk("w8_hi_after", hi8, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised, iterative multiply/divide unit that owns the HI/LO register pair for the multi-cycle MIPS core.
- It replaces single-cycle unsigned `*`, `/` and `%` in Execute with a shift-add multiplier and a restoring divider.
- Adds signed modes and a busy/done handshake; the core stalls in Execute while busy is high.
- The core reads hi/lo directly for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits. Legal: even, 8..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 reserved (ignored).
- operand_a  in  WIDTH  rS value (multiplicand / dividend / MTHI/MTLO source).
- operand_b  in  WIDTH  rT value (multiplier / divisor).
- busy  out  1  an iterative op is in flight.
- done  out  1  one-cycle pulse: hi/lo hold the new result.
- div_by_zero  out  1  sticky flag from the last DIV/DIVU; cleared by the next accepted MULT/MULTU/DIV/DIVU.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0.
  - Any in-flight op is discarded; hi/lo are not updated by it.
- States: IDLE, MUL_ITER, DIV_ITER, FIX.
- IDLE, accept edge (start=1 and busy=0):
  - MTHI: hi<=operand_a, same edge; busy stays 0; no done pulse; stay IDLE.
  - MTLO: lo<=operand_a, likewise.
  - MULT/MULTU/DIV/DIVU:
    - Latch the magnitudes of a and b. Signed ops take the two's-complement absolute value; unsigned ops pass through.
    - Latch neg_q = a_sign ^ b_sign and neg_r = a_sign (both 0 for unsigned ops).
    - counter<=WIDTH; busy<=1; done<=0.
    - Go to MUL_ITER or DIV_ITER.
  - op 6/7: ignored; nothing changes.
- MUL_ITER: one shift-add step per cycle on a 2*WIDTH accumulator, LSB-first; counter-=1; at counter==1 go to FIX.
- DIV_ITER: one restoring step per cycle: shift remainder, trial subtract, set quotient bit; counter-=1; at counter==1 go to FIX.
- FIX edge:
  - Apply sign correction: product negated if neg_q; quotient negated if neg_q; remainder negated if neg_r.
  - Multiply writes {hi,lo}<=product. Divide writes hi<=remainder, lo<=quotient.
  - busy<=0, done<=1, next state IDLE.
- Latency:
  - Accept edge = E0; iteration edges E1..E(WIDTH-1); FIX edge = E(WIDTH).
  - done is high during the cycle after E(WIDTH); busy is high from E0 to E(WIDTH).
  - The next request may be accepted at E(WIDTH+1), i.e. in the cycle where done=1.
- done deasserts on the edge after it was set, unconditionally.
- start while busy=1: ignored; operands, op and hi/lo are unaffected. The core must hold start until busy=0.
- Divide by zero (operand_b==0, either mode):
  - Sign correction is bypassed.
  - hi<=operand_a (raw), lo<={WIDTH{1'b1}}, div_by_zero<=1.
  - Same latency as a normal divide.
- Signed overflow, DIV of -2^(WIDTH-1) by -1: lo=-2^(WIDTH-1) (wraps), hi=0, div_by_zero=0.
- Signed MULT of -2^(WIDTH-1) by itself: {hi,lo}=2^(2*WIDTH-2); no overflow is possible.
- Reset asserted mid-op: immediate return to IDLE; hi/lo show 0.

Decomposition:
- Package mdu_pkg holds:
  - op encodings: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO;
  - state encoding: MDU_IDLE, MDU_MUL_ITER, MDU_DIV_ITER, MDU_FIX.
- The core's Execute stage imports the same op constants for its funct-to-op mapping.
- One natural sub-module: mdu_cond_negate (WIDTH-parametrised, combinational: out = neg ? -in : in). It is instantiated for operand magnitudes and FIX correction; everything else stays in mul_div_unit.

Test Plan:
- MULTU, WIDTH=32, a=0xFFFF_FFFF, b=0xFFFF_FFFF -> done 32 cycles after accept edge; hi=0xFFFF_FFFE, lo=0x0000_0001; busy high for exactly 32 cycles.
- MULT, a=-7 (0xFFFF_FFF9), b=6 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFD6 (-42); then DIV, a=-7, b=2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
- DIVU, a=100, b=0 -> lo=0xFFFF_FFFF, hi=100, div_by_zero=1; next MULTU 3*4 -> lo=12, hi=0, div_by_zero=0.
- DIV, a=0x8000_0000, b=0xFFFF_FFFF -> lo=0x8000_0000, hi=0. MULT 0x8000_0000*0x8000_0000 -> hi=0x4000_0000, lo=0.
- MTHI 0x1234 then MTLO 0x5678 on consecutive edges -> hi=0x1234, lo=0x5678, busy never asserts, no done. Start with op=DIVU pulsed mid-MULTU -> ignored; the MULTU result is correct.
- WIDTH=8 build: DIVU 200/7 -> lo=28, hi=4, done 8 cycles after accept. rst_n low at iteration 3 of a DIVU -> busy=0, hi=lo=0 immediately (async), no done pulse.
